// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache sitting between fetch and memory_control.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_EN.
module icache_direct #(
  parameter int INDEX_BITS = 7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        jump_or_not_in,
  input  logic        fetch_req_in,
  input  logic [31:0] fetch_pc_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic        icache_busy_out,
  output logic        inst_enable_out,
  output logic [31:0] inst_address_out,
  input  logic        inst_enable_in,
  input  logic [31:0] inst_data_in
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count_out,
  output logic [31:0] miss_count_out
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

  state_t                  state_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem [LINES];
  logic [31:0]             data_mem [LINES];
  logic                    inst_valid_q;
  logic [31:0]             inst_q;
  logic                    busy_q;
  logic                    enable_q;
  logic [31:0]             addr_q;

  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    lookup_hit;
  logic                    accept;
  logic                    fill_en;
  logic                    unused_pc_bits;

  assign req_idx        = fetch_pc_in[INDEX_BITS+1:2];
  assign req_tag        = fetch_pc_in[31:INDEX_BITS+2];
  assign fill_idx       = addr_q[INDEX_BITS+1:2];
  assign fill_tag       = addr_q[31:INDEX_BITS+2];
  assign lookup_hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept         = (state_q == IDLE) && fetch_req_in && !jump_or_not_in;
  // A reply arriving together with a jump still fills the line; only forwarding is suppressed.
  assign fill_en        = (state_q == MISS) && inst_enable_in;
  assign unused_pc_bits = ^fetch_pc_in[1:0];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      busy_q       <= 1'b0;
      enable_q     <= 1'b0;
      addr_q       <= '0;
    end else begin
      inst_valid_q <= 1'b0;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
      if (jump_or_not_in) begin
        state_q  <= IDLE;
        enable_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              if (lookup_hit) begin
                inst_q       <= data_mem[req_idx];
                inst_valid_q <= 1'b1;
              end else begin
                addr_q   <= {fetch_pc_in[31:2], 2'b00};
                enable_q <= 1'b1;
                busy_q   <= 1'b1;
                state_q  <= MISS;
              end
            end
          end
          MISS: begin
            if (inst_enable_in) begin
              inst_q       <= inst_data_in;
              inst_valid_q <= 1'b1;
              enable_q     <= 1'b0;
              busy_q       <= 1'b0;
              state_q      <= RESP;
            end
          end
          // Guarantees inst_enable_out stays low at least one cycle between requests.
          RESP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= inst_data_in;
    end
  end

  assign inst_valid_out   = inst_valid_q;
  assign inst_out         = inst_q;
  assign icache_busy_out  = busy_q;
  assign inst_enable_out  = enable_q;
  assign inst_address_out = addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Aborted misses still count: the miss is tallied when MISS is entered.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept && lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (accept && !lookup_hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_out  = hit_cnt_q;
  assign miss_count_out = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Randomized self-checking bench for icache_direct against an address-keyed cache model.
// Define ICACHE_PERF_EN on both bench and RTL to also check the performance counters.
module tb_icache_direct;

  localparam int INDEX_BITS = 7;
  localparam int LINES      = 1 << INDEX_BITS;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        jump_or_not_in;
  logic        fetch_req_in;
  logic [31:0] fetch_pc_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic        icache_busy_out;
  logic        inst_enable_out;
  logic [31:0] inst_address_out;
  logic        inst_enable_in;
  logic [31:0] inst_data_in;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_out;
  logic [31:0] miss_count_out;
`endif

  icache_direct #(.INDEX_BITS(INDEX_BITS)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .jump_or_not_in   (jump_or_not_in),
    .fetch_req_in     (fetch_req_in),
    .fetch_pc_in      (fetch_pc_in),
    .inst_valid_out   (inst_valid_out),
    .inst_out         (inst_out),
    .icache_busy_out  (icache_busy_out),
    .inst_enable_out  (inst_enable_out),
    .inst_address_out (inst_address_out),
    .inst_enable_in   (inst_enable_in),
    .inst_data_in     (inst_data_in)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count_out    (hit_count_out),
    .miss_count_out   (miss_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Model: each line index maps to the word address it holds and that word's data.
  logic [31:0] m_addr [int];
  logic [31:0] m_data [int];
  int unsigned m_hits   = 0;
  int unsigned m_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc >> 2) % LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int idx = line_of(pc);
    return m_addr.exists(idx) && (m_addr[idx] == (pc & ~32'h3));
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, inst_valid_out, 0);
    check({tag, "_en"}, inst_enable_out, 0);
    check({tag, "_busy"}, icache_busy_out, 0);
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] fill, input int delay);
    int idx = line_of(pc);
    if (model_hit(pc)) begin
      fetch_req_in = 1'b1; fetch_pc_in = pc;
      step();
      fetch_req_in = 1'b0; fetch_pc_in = $urandom;
      m_hits++;
      check("hit_valid", inst_valid_out, 1);
      check("hit_data", inst_out, m_data[idx]);
      check("hit_no_mem_req", inst_enable_out, 0);
      step();
      check("hit_pulse_end", inst_valid_out, 0);
    end else begin
      fetch_req_in = 1'b1; fetch_pc_in = pc;
      step();
      m_misses++;
      check("miss_en", inst_enable_out, 1);
      check("miss_addr", inst_address_out, pc & ~32'h3);
      check("miss_busy", icache_busy_out, 1);
      check("miss_no_valid", inst_valid_out, 0);
      for (int i = 0; i < delay; i++) begin
        fetch_req_in = 1'($urandom_range(0, 1)); fetch_pc_in = $urandom;
        step();
        check("miss_hold_en", inst_enable_out, 1);
        check("miss_hold_addr", inst_address_out, pc & ~32'h3);
        check("miss_hold_no_valid", inst_valid_out, 0);
      end
      fetch_req_in = 1'b0;
      inst_enable_in = 1'b1; inst_data_in = fill;
      step();
      inst_enable_in = 1'b0; inst_data_in = $urandom;
      check("fill_valid", inst_valid_out, 1);
      check("fill_data", inst_out, fill);
      check("fill_en_low", inst_enable_out, 0);
      check("fill_busy_low", icache_busy_out, 0);
      m_addr[idx] = pc & ~32'h3;
      m_data[idx] = fill;
      // A request during the recovery cycle must be ignored.
      fetch_req_in = 1'($urandom_range(0, 1)); fetch_pc_in = $urandom;
      step();
      fetch_req_in = 1'b0;
      check("resp_pulse_end", inst_valid_out, 0);
      check("resp_req_ignored", inst_enable_out, 0);
    end
  endtask

  task automatic jump_miss(input logic [31:0] pc, input int k, input bit coincide,
                           input logic [31:0] fill);
    int idx = line_of(pc);
    if (model_hit(pc)) begin
      do_fetch(pc, fill, 1);
      return;
    end
    fetch_req_in = 1'b1; fetch_pc_in = pc;
    step();
    m_misses++;
    check("jm_en", inst_enable_out, 1);
    for (int i = 0; i < k; i++) begin
      fetch_req_in = 1'($urandom_range(0, 1)); fetch_pc_in = $urandom;
      step();
      check("jm_hold_en", inst_enable_out, 1);
    end
    jump_or_not_in = 1'b1;
    fetch_req_in   = 1'b1; fetch_pc_in = $urandom;
    if (coincide) begin
      inst_enable_in = 1'b1; inst_data_in = fill;
    end
    step();
    jump_or_not_in = 1'b0; fetch_req_in = 1'b0; inst_enable_in = 1'b0;
    check_idle_outputs("jump");
    if (coincide) begin
      m_addr[idx] = pc & ~32'h3;
      m_data[idx] = fill;
    end
    inst_enable_in = 1'b1; inst_data_in = $urandom;
    step();
    inst_enable_in = 1'b0;
    check("stray_reply_valid", inst_valid_out, 0);
    check("stray_reply_en", inst_enable_out, 0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] tags [4];
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h7FFFFF; tags[3] = 32'h400000;
    return (tags[$urandom_range(0, 3)] << (INDEX_BITS + 2))
         | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic check_perf(input string tag);
`ifdef ICACHE_PERF_EN
    check({tag, "_hits"}, hit_count_out, m_hits);
    check({tag, "_misses"}, miss_count_out, m_misses);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; jump_or_not_in = 1'b0; fetch_req_in = 1'b0; fetch_pc_in = '0;
    inst_enable_in = 1'b0; inst_data_in = '0;
    #12;
    check_idle_outputs("reset");
    check("reset_addr", inst_address_out, 0);
    check("reset_data", inst_out, 0);
    check_perf("reset");
    @(posedge clk_in); #1 rst_in = 1'b1;
    step();

    do_fetch(32'h4, 32'h00100093, 4);
    do_fetch(32'h4, 32'h0, 0);
    do_fetch(32'h8, 32'h00200113, 2);

    fetch_req_in = 1'b1; fetch_pc_in = 32'h4;
    step();
    check("b2b_first_valid", inst_valid_out, 1);
    check("b2b_first_data", inst_out, 32'h00100093);
    fetch_pc_in = 32'h8;
    step();
    fetch_req_in = 1'b0;
    check("b2b_second_valid", inst_valid_out, 1);
    check("b2b_second_data", inst_out, 32'h00200113);
    m_hits += 2;
    step();
    check("b2b_end", inst_valid_out, 0);

    do_fetch(32'h204, 32'h11112222, 1);
    do_fetch(32'h4, 32'h00100093, 1);

    jump_miss(32'h10, 1, 1'b0, 32'h0);
    do_fetch(32'h10, 32'h33334444, 2);

    jump_miss(32'h20, 2, 1'b1, 32'hDEADBEEF);
    do_fetch(32'h20, 32'h0, 0);
    check("jump_fill_kept", inst_out, 32'hDEADBEEF);

    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 9);
      if (r == 0)      jump_miss(rand_pc(), $urandom_range(0, 3), 1'b0, $urandom);
      else if (r == 1) jump_miss(rand_pc(), $urandom_range(0, 3), 1'b1, $urandom);
      else             do_fetch(rand_pc(), $urandom, $urandom_range(0, 5));
    end
    check_perf("random");

    fetch_req_in = 1'b1; fetch_pc_in = 32'hFFFF_FF00;
    step();
    fetch_req_in = 1'b0;
    check("prereset_miss_en", inst_enable_out, 1);
    #2 rst_in = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_addr", inst_address_out, 0);
    m_addr.delete(); m_data.delete();
    m_hits = 0; m_misses = 0;
    check_perf("async_reset");
    @(posedge clk_in); #1 rst_in = 1'b1;
    inst_enable_in = 1'b1; inst_data_in = 32'hBAD0BAD0;
    step();
    inst_enable_in = 1'b0;
    check_idle_outputs("post_reset_stray");
    do_fetch(32'h4, 32'h55556666, 1);
    check_perf("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
